// File: rtl/bus_pkg.sv
// Shared types and constants for the bidding bus masters: FSM/error encodings,
// the balance mirror constants and the effective-bid rule.
package bus_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BID, S_XFER, S_RESP} state_t;
    typedef enum logic [1:0] {ERR_OK, ERR_BAD_ADDR, ERR_TIMEOUT, ERR_PREEMPT} err_t;

    localparam logic [9:0] BAL_INIT   = 10'd750;
    localparam logic [9:0] BAL_CAP    = 10'd900;
    localparam logic [9:0] BAL_REFILL = 10'd750;
    localparam logic [9:0] BAL_THRESH = 10'd150;
    localparam logic [8:0] PERIOD     = 9'd400;
    localparam logic [3:0] SLV_MAX    = 4'd3;

    // A bid must stay strictly below the balance to remain eligible; b >= bal
    // implies bal <= 15, so the low nibble of bal is the whole value there.
    function automatic logic [3:0] eff_bid(input logic [3:0] bid, input logic [9:0] bal);
        logic [3:0] b;
        b = (bid == 4'd0) ? 4'd1 : bid;
        if ({6'd0, b} >= bal) b = (bal <= 10'd1) ? 4'd1 : bal[3:0] - 4'd1;
        return b;
    endfunction

endpackage

// File: rtl/bal_mirror.sv
// Local copy of the arbiter's per-master bank balance: periodic refill,
// deduction of the active bid on every granted cycle.
module bal_mirror
    import bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       grant,
    input  logic [3:0] bid,
    output logic [9:0] balance
);

    logic [8:0] cnt_q, cnt_d;
    logic [9:0] bal_q, bal_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            bal_q <= BAL_INIT;
        end else begin
            cnt_q <= cnt_d;
            bal_q <= bal_d;
        end
    end

    // Refill wins over a deduction in the same cycle; balance never reaches 0.
    always_comb begin
        cnt_d = (cnt_q == PERIOD) ? 9'd0 : cnt_q + 9'd1;
        bal_d = bal_q;
        if (cnt_q == PERIOD)
            bal_d = (bal_q > BAL_THRESH) ? BAL_CAP : bal_q + BAL_REFILL;
        else if (grant)
            bal_d = (bal_q > {6'd0, bid}) ? bal_q - {6'd0, bid} : 10'd1;
    end

    assign balance = bal_q;

endmodule

// File: rtl/bid_master.sv
// Bus-master initiator: accepts a local command, bids to the arbiter until
// granted, runs the slave transfer and returns a one-cycle response.
module bid_master
    import bus_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int XFER_CYCLES   = 2,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [15:0]       cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_bid,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [3:0]        req,
    input  logic              grant,
    output logic [15:0]       addr,
    output logic              RW,
    output logic [DATA_W-1:0] DataToSlave,
    input  logic [DATA_W-1:0] DataFromSlave,
    output state_t            dbg_state_o,
    output logic [9:0]        dbg_balance_o
);

    localparam logic [9:0] TO_LAST = 10'(GRANT_TIMEOUT - 1);
    localparam logic [9:0] XF_LAST = 10'(XFER_CYCLES - 1);

    state_t            state_q, state_d;
    err_t              err_q, err_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [3:0]        bid_q, bid_d;
    logic [3:0]        req_q, req_d;
    logic              rw_q, rw_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [9:0]        balance;

    bal_mirror u_bal (
        .clk     (clk),
        .rst     (rst),
        .grant   (grant),
        .bid     (bid_q),
        .balance (balance)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            err_q       <= ERR_OK;
            cnt_q       <= '0;
            bid_q       <= '0;
            req_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            bid_q       <= bid_d;
            req_q       <= req_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on the state.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        bid_d   = bid_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    bid_d   = eff_bid(cmd_bid, balance);
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (cmd_addr[15:12] > SLV_MAX) begin
                        err_d   = ERR_BAD_ADDR;
                        state_d = S_RESP;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = S_BID;
                    end
                end
            end
            S_BID: begin
                // A grant on the final wait cycle still wins over the timeout.
                if (grant) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_XFER: begin
                if (!grant) begin
                    err_d   = ERR_PREEMPT;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (cnt_q == XF_LAST) begin
                    if (!rw_q) rdata_d = DataFromSlave;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_d       = (state_d == S_BID || state_d == S_XFER) ? bid_d : 4'd0;
        rsp_valid_d = (state_d == S_RESP);
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign req           = req_q;
    assign addr          = addr_q;
    assign RW            = rw_q;
    assign DataToSlave   = wdata_q;
    assign dbg_state_o   = state_q;
    assign dbg_balance_o = balance;

endmodule

// File: tb/tb_bid_master.sv
// Directed bench for bid_master: table of single transactions, then reset in
// XFER, a balance clamp run and the periodic refill.
module tb_bid_master;
    import bus_pkg::*;

    localparam int XC = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [3:0]  cmd_bid;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_err;
    logic [3:0]  req;
    logic        grant;
    logic [15:0] addr;
    logic        RW;
    logic [7:0]  DataToSlave, DataFromSlave;
    state_t      dbg_state;
    logic [9:0]  dbg_balance;

    int n_chk = 0, n_pass = 0;
    int g_dly = 0, g_lim = 0, exp_b = 0;
    int dcnt = 0, gcnt = 0;
    int m_cnt, m_bal;

    bid_master #(.DATA_W(8), .XFER_CYCLES(XC), .GRANT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_bid(cmd_bid),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .req(req), .grant(grant), .addr(addr), .RW(RW),
        .DataToSlave(DataToSlave), .DataFromSlave(DataFromSlave),
        .dbg_state_o(dbg_state), .dbg_balance_o(dbg_balance)
    );

    always #5 clk = ~clk;

    // Arbiter stand-in: combinational on req, grant after g_dly requesting
    // cycles, for at most g_lim cycles per transaction.
    assign grant = (req != 4'd0) && (dcnt >= g_dly) && (gcnt < g_lim);

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            dcnt <= 0;
            gcnt <= 0;
        end else begin
            if (req != 4'd0) dcnt <= dcnt + 1;
            if (grant) gcnt <= gcnt + 1;
        end
    end

    // Reference balance: refill at count 400, else deduct the bid when granted.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= 0;
            m_bal <= 750;
        end else begin
            m_cnt <= (m_cnt == 400) ? 0 : m_cnt + 1;
            if (m_cnt == 400) m_bal <= (m_bal > 150) ? 900 : m_bal + 750;
            else if (grant) m_bal <= (m_bal - exp_b < 1) ? 1 : m_bal - exp_b;
        end
    end

    function automatic int ref_bid(input int bid, input int bal);
        int b;
        b = (bid < 1) ? 1 : bid;
        if (b >= bal) b = bal - 1;
        if (b < 1) b = 1;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    task automatic issue(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                         input logic [3:0] bid, input int dly, input int lim, input logic [7:0] sd);
        int w;
        @(negedge clk);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = wd; cmd_bid = bid;
        g_dly = dly; g_lim = lim; DataFromSlave = sd;
        cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        exp_b = ref_bid(int'(bid), m_bal);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Latency is counted inclusively from the accept cycle to the rsp_valid cycle.
    task automatic watch(input string tag, input logic rw, input logic [15:0] a, input logic [7:0] wd,
                         input logic [1:0] e_err, input logic [7:0] e_rd, input int e_lat, input int e_reqc);
        int lat, reqc, bad;
        logic [7:0] rd;
        logic [1:0] er;
        logic [3:0] req_r;
        lat = -1; reqc = 0; bad = 0; rd = '0; er = '0; req_r = '0;
        for (int k = 0; k <= 40 && lat < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (req != 4'd0) begin
                reqc++;
                if (req !== 4'(exp_b) || addr !== a || RW !== rw || DataToSlave !== wd) bad++;
            end
            if (rsp_valid === 1'b1) begin
                lat = k + 2; rd = rsp_rdata; er = rsp_err; req_r = req;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
        chk({tag, "_err"}, {30'd0, er}, {30'd0, e_err});
        chk({tag, "_rdata"}, {24'd0, rd}, {24'd0, e_rd});
        chk({tag, "_req_cycles"}, 32'(reqc), 32'(e_reqc));
        chk({tag, "_bus_hold"}, 32'(bad), 32'd0);
        chk({tag, "_req_in_resp"}, {28'd0, req_r}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_balance"}, {22'd0, dbg_balance}, 32'(m_bal));
    endtask

    typedef struct {
        logic rw; logic [15:0] a; logic [7:0] wd; logic [3:0] bid;
        int dly; int lim; logic [7:0] sd;
        logic [1:0] e_err; logic [7:0] e_rd; int e_lat; int e_reqc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int seen, w;
        vecs[0] = '{1'b0, 16'h1004, 8'h00, 4'd5, 0,    1000, 8'hA5, 2'd0, 8'hA5, 5,  3};
        vecs[1] = '{1'b1, 16'h3010, 8'h5C, 4'd0, 0,    1000, 8'hEE, 2'd0, 8'h00, 5,  3};
        vecs[2] = '{1'b1, 16'h5000, 8'h11, 4'd3, 0,    1000, 8'h00, 2'd1, 8'h00, 2,  0};
        vecs[3] = '{1'b0, 16'h4000, 8'h00, 4'd3, 0,    1000, 8'h99, 2'd1, 8'h00, 2,  0};
        vecs[4] = '{1'b0, 16'h3FFF, 8'h00, 4'd2, 0,    1000, 8'h5A, 2'd0, 8'h5A, 5,  3};
        vecs[5] = '{1'b0, 16'h2000, 8'h00, 4'd4, 1000, 1000, 8'h77, 2'd2, 8'h00, 10, 8};
        vecs[6] = '{1'b0, 16'h0001, 8'h00, 4'd4, 7,    1000, 8'h3C, 2'd0, 8'h3C, 12, 10};
        vecs[7] = '{1'b0, 16'h1234, 8'h00, 4'd6, 0,    1,    8'h66, 2'd3, 8'h00, 4,  2};
        vecs[8] = '{1'b0, 16'h0000, 8'h00, 4'd6, 0,    2,    8'h66, 2'd3, 8'h00, 5,  3};

        rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_bid = '0; DataFromSlave = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {28'd0, req}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_addr", {16'd0, addr}, 32'd0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        chk("rst_balance", {22'd0, dbg_balance}, 32'd750);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].rw, vecs[i].a, vecs[i].wd, vecs[i].bid, vecs[i].dly, vecs[i].lim, vecs[i].sd);
            watch($sformatf("vec%0d", i), vecs[i].rw, vecs[i].a, vecs[i].wd,
                  vecs[i].e_err, vecs[i].e_rd, vecs[i].e_lat, vecs[i].e_reqc);
        end

        // Reset asserted while the transfer is in progress.
        issue(1'b1, 16'h2020, 8'hC3, 4'd7, 0, 1000, 8'h00);
        @(posedge clk);
        #1;
        chk("mid_in_xfer", {30'd0, dbg_state}, {30'd0, S_XFER});
        #2 rst = 1'b0;
        #1;
        chk("mid_req", {28'd0, req}, 32'd0);
        chk("mid_addr", {16'd0, addr}, 32'd0);
        chk("mid_rw", {31'd0, RW}, 32'd0);
        chk("mid_wdata", {24'd0, DataToSlave}, 32'd0);
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("mid_rsp_err", {30'd0, rsp_err}, 32'd0);
        chk("mid_balance", {22'd0, dbg_balance}, 32'd750);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);
        chk("mid_ready", {31'd0, cmd_ready}, 32'd1);

        // Clamp run: 16 x bid 15 takes 750 down to 30, a bid 5 leaves 15,
        // then bid 15 is trimmed to 14 and later to 1.
        for (int i = 0; i < 20; i++) begin
            issue(1'b0, 16'h2000, 8'h00, (i == 16) ? 4'd5 : 4'd15, 0, 1000, 8'h42);
            if (i == 17) chk("clamp_req14", 32'(exp_b), 32'd14);
            watch($sformatf("clamp%0d", i), 1'b0, 16'h2000, 8'h00, 2'd0, 8'h42, 5, 3);
        end
        chk("clamp_floor", {22'd0, dbg_balance}, 32'd1);

        for (int r = 0; r < 2; r++) begin
            w = 0;
            while (m_cnt != 400 && w < 1000) begin
                @(posedge clk);
                #1;
                w++;
            end
            chk($sformatf("period_wait%0d", r), 32'(m_cnt), 32'd400);
            @(posedge clk);
            #1;
            chk($sformatf("refill%0d", r), {22'd0, dbg_balance}, (r == 0) ? 32'd751 : 32'd900);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
